// File: rtl/debug_display_scanner.sv
// Multiplexed 7-segment hex viewer for NUM_CH debug channels, paged by a debounced push button.
// Optional freeze/hold behaviour is compiled in with `define DISP_FREEZE_EN.
module debug_display_scanner #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CH       = 4,
  parameter int NUM_DIGITS   = DATA_WIDTH/4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                         btn_next,
  input  logic                         freeze,
  output logic [6:0]                   seg_n,
  output logic [NUM_DIGITS-1:0]        dig_en_n,
  output logic [$clog2(NUM_CH)-1:0]    page
);

  localparam int PW = $clog2(NUM_CH);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(NUM_CH - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch;
  assign ch = ch_data;

  logic                  frz;
`ifdef DISP_FREEZE_EN
  assign frz = freeze;
`else
  logic unused_freeze;
  assign unused_freeze = freeze;
  assign frz           = 1'b0;
`endif

  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic [PW-1:0]         page_q,  page_d;
  logic [DATA_WIDTH-1:0] disp_q,  disp_d;
  logic [1:0]            sync_q;
  logic                  level_q, level_d;
  logic [DW-1:0]         dbc_q,   dbc_d;
  logic [6:0]            seg_q,   seg_d;
  logic [NUM_DIGITS-1:0] dig_q,   dig_d;

  logic       tick, synced, accept;
  logic [3:0] nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Scan timing and frame capture; the load uses page_q, i.e. the pre-increment page.
  always_comb begin
    tick   = (cnt_q == SCAN_LAST);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    disp_d = disp_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (idx_q == IDX_LAST && !frz)
        disp_d = ch[page_q];
    end
  end

  // Debounce: a level differing from the accepted one must persist DEBOUNCE_CYC samples.
  always_comb begin
    synced  = sync_q[1];
    accept  = 1'b0;
    level_d = level_q;
    dbc_d   = '0;
    if (synced != level_q) begin
      if (dbc_q == DB_LAST) begin
        accept  = 1'b1;
        level_d = synced;
      end else begin
        dbc_d = dbc_q + 1'b1;
      end
    end
    page_d = page_q;
    if (accept && synced && !frz)
      page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
  end

  // Segment and digit enables are computed from next-state so both land together.
  always_comb begin
    nib   = disp_d[{idx_d, 2'b00} +: 4];
    seg_d = seg_q;
    dig_d = dig_q;
    if (tick) begin
      seg_d = glyph(nib);
      dig_d = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= IDX_LAST;
      page_q  <= '0;
      disp_q  <= '0;
      sync_q  <= '0;
      level_q <= 1'b0;
      dbc_q   <= '0;
      seg_q   <= '1;
      dig_q   <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      disp_q  <= disp_d;
      sync_q  <= {sync_q[0], btn_next};
      level_q <= level_d;
      dbc_q   <= dbc_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg_n    = seg_q;
  assign dig_en_n = dig_q;
  assign page     = page_q;

endmodule

// File: tb/tb_debug_display_scanner.sv
// Randomized scoreboard bench for debug_display_scanner (small configuration).
module tb_debug_display_scanner;
  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int ND  = 2;
  localparam int SD  = 4;
  localparam int DB  = 3;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic              btn_next = 1'b0;
  logic              freeze = 1'b0;
  logic [6:0]        seg_n;
  logic [ND-1:0]     dig_en_n;
  logic [1:0]        page;

  debug_display_scanner #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEBOUNCE_CYC(DB)
  ) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .btn_next(btn_next), .freeze(freeze),
    .seg_n(seg_n), .dig_en_n(dig_en_n), .page(page)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] dig;
    logic [1:0]    pg;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a sample of ch[page] taken every ND*SD cycles,
  // the button level is the 2-cycle-delayed input filtered by a run-length rule.
  int          m_cyc, m_idx, m_page, m_run;
  logic        m_level, m_b0, m_b1, m_syn, m_fz, m_tick;
  logic [DW-1:0] m_frame;
  logic [3:0]  m_nib;
  exp_t        m_e;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_idx = ND-1; m_page = 0; m_run = 0;
      m_level = 1'b0; m_b0 = 1'b0; m_b1 = 1'b0; m_frame = '0;
    end else begin
`ifdef DISP_FREEZE_EN
      m_fz = freeze;
`else
      m_fz = 1'b0;
`endif
      m_syn = m_b1; m_b1 = m_b0; m_b0 = btn_next;
      m_cyc++;
      m_tick = (m_cyc % SD == 0);
      if (m_tick) begin
        m_idx = (m_idx + 1) % ND;
        if (m_idx == 0 && !m_fz) m_frame = ch_data[m_page*DW +: DW];
      end
      m_run = (m_syn != m_level) ? m_run + 1 : 0;
      if (m_run == DB) begin
        m_run = 0;
        m_level = m_syn;
        if (m_level && !m_fz) m_page = (m_page + 1) % NCH;
      end
      if (m_tick) begin
        m_nib   = m_frame[4*m_idx +: 4];
        m_e.seg = GLYPH[m_nib];
        m_e.dig = ~(ND'(1) << m_idx);
        m_e.pg  = 2'(m_page);
        q.push_back(m_e);
      end
    end
  end

  // Monitor: every digit-enable change is one presented output.
  logic [ND-1:0] prev_dig = '1;
  int            idle = 0;
  exp_t          got_e;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_seg", 32'(seg_n), 32'h7f);
      chk("reset_dig", 32'(dig_en_n), 32'(2'b11));
      chk("reset_page", 32'(page), 32'h0);
      q.delete();
      prev_dig = '1;
      idle = 0;
    end else if (dig_en_n !== prev_dig) begin
      prev_dig = dig_en_n;
      idle = 0;
      if (q.size() == 0) begin
        chk("unexpected_update", 32'(dig_en_n), 32'(prev_dig ^ 2'b11));
      end else begin
        got_e = q.pop_front();
        chk("seg_n", 32'(seg_n), 32'(got_e.seg));
        chk("dig_en_n", 32'(dig_en_n), 32'(got_e.dig));
        chk("page", 32'(page), 32'(got_e.pg));
      end
    end else begin
      idle++;
      if (idle > 2*SD) begin
        n_cmp++; n_err++;
        $display("FAIL scan_timeout: no digit update for %0d cycles, need one every %0d", idle, SD);
        idle = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input int hi, input int lo);
    btn_next = 1'b1; step(hi);
    btn_next = 1'b0; step(lo);
  endtask

  int r;

  initial begin
    #2 rst = 1'b1;
    step(3);
    ch_data = {8'h77, 8'h3C, 8'h5A};
    rst = 1'b0;
    step(4*SD*ND);

    press(10, 10);
    chk("page_after_hold", 32'(page), 32'h1);
    step(2*SD*ND);
    press(10, 10);
    chk("page_second", 32'(page), 32'h2);
    press(10, 10);
    chk("page_wrap", 32'(page), 32'h0);
    press(2, 10);
    chk("page_short_pulse", 32'(page), 32'h0);

    ch_data[7:0] = 8'h12;
    step(3*SD*ND);
    freeze = 1'b1;
    ch_data[7:0] = 8'h34;
    press(10, 10);
    step(2*SD*ND);
`ifdef DISP_FREEZE_EN
    chk("page_frozen", 32'(page), 32'h0);
`else
    chk("page_not_frozen", 32'(page), 32'h1);
`endif
    freeze = 1'b0;
    step(3*SD*ND);

    step(SD + 1);
    rst = 1'b1;
    #1;
    chk("midframe_seg", 32'(seg_n), 32'h7f);
    chk("midframe_dig", 32'(dig_en_n), 32'(2'b11));
    chk("midframe_page", 32'(page), 32'h0);
    step(2);
    rst = 1'b0;
    step(2*SD*ND);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) press($urandom_range(1, 8), $urandom_range(1, 8));
      else if (r <= 4) begin ch_data = NCH*DW'($urandom); step(1); end
      else if (r == 5) begin freeze = ~freeze; step($urandom_range(1, 4)); end
      else if (r == 6 && $urandom_range(0, 3) == 0) begin
        rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0; step(1);
      end else step($urandom_range(1, 6));
    end

    freeze = 1'b0;
    btn_next = 1'b0;
    step(2*SD*ND);
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
